cmp_arbiter: RTL and testbench

Two-port arbiter that shares one 64-bit compare datapath between the branch-resolution logic (port 0) and the set-less-than ALU path (port 1). It accepts valid/ready requests carrying two operands and a compare opcode, and grants one request per cycle using round-robin. It evaluates the compare and holds the result in a single-entry output register until the consumer takes it. It sits between the decode/issue stage and the execute-stage writeback/redirect logic.

---
 rtl/cmp_pkg.sv | 13 +
 rtl/cmp_core.sv | 25 ++
 rtl/cmp_arbiter.sv | 99 +++++++++
 tb/tb_cmp_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared opcode and width definitions for the compare arbiter slice.
package cmp_pkg;

  localparam int unsigned OP_W = 4;
  localparam int unsigned ID_W = 1;

  localparam logic [OP_W-1:0] CMP_NEQ_U = 4'd0;
  localparam logic [OP_W-1:0] CMP_EQ    = 4'd1;
  localparam logic [OP_W-1:0] CMP_GE_S  = 4'd2;
  localparam logic [OP_W-1:0] CMP_LT_S  = 4'd3;
  localparam logic [OP_W-1:0] CMP_LT_U  = 4'd4;

endpackage

// File: rtl/cmp_core.sv
// Shared combinational comparator; unlisted opcodes evaluate to false.
module cmp_core
  import cmp_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [OP_W-1:0] op,
  output logic            flag
);

  always_comb begin
    flag = 1'b0;
    case (op)
      CMP_NEQ_U: flag = (src1 != src2);
      CMP_EQ:    flag = (src1 == src2);
      CMP_GE_S:  flag = ($signed(src1) >= $signed(src2));
      CMP_LT_S:  flag = ($signed(src1) <  $signed(src2));
      CMP_LT_U:  flag = (src1 < src2);
      default:   flag = 1'b0;
    endcase
  end

endmodule

// File: rtl/cmp_arbiter.sv
// Two-port arbiter sharing one comparator, with a single-entry result buffer.
// Build option: CMP_ARB_FIXED_PRIO_EN selects fixed priority (port 0 wins) over round-robin.
module cmp_arbiter
  import cmp_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_src1,
  input  logic [XLEN-1:0] req0_src2,
  input  logic [OP_W-1:0] req0_op,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_src1,
  input  logic [XLEN-1:0] req1_src2,
  input  logic [OP_W-1:0] req1_op,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [ID_W-1:0] rsp_id,
  output logic [XLEN-1:0] rsp_result,
  output logic            rsp_flag
);

  logic            slot_free;
  logic            grant0;
  logic            grant1;
  logic            accept;
  logic            sel;
  logic [XLEN-1:0] src1_sel;
  logic [XLEN-1:0] src2_sel;
  logic [OP_W-1:0] op_sel;
  logic            flag_c;

`ifdef CMP_ARB_FIXED_PRIO_EN
  // Port 0 always wins contention; port 1 may starve.
  always_comb begin
    grant0 = req0_valid;
    grant1 = req1_valid && !req0_valid;
  end
`else
  logic last;

  // On contention, grant the port that did not win the last accepted handshake.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || last);
    grant1 = req1_valid && (!req0_valid || !last);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= 1'b1;
    end else if (accept) begin
      last <= sel;
    end
  end
`endif

  // Readies are forced low while reset is held.
  always_comb begin
    slot_free  = !rsp_valid || rsp_ready;
    req0_ready = grant0 && slot_free && !rst;
    req1_ready = grant1 && slot_free && !rst;
    accept     = req0_ready || req1_ready;
    sel        = req1_ready;
    src1_sel   = sel ? req1_src1 : req0_src1;
    src2_sel   = sel ? req1_src2 : req0_src2;
    op_sel     = sel ? req1_op   : req0_op;
  end

  cmp_core #(
    .XLEN (XLEN)
  ) u_cmp_core (
    .src1 (src1_sel),
    .src2 (src2_sel),
    .op   (op_sel),
    .flag (flag_c)
  );

  // Data fields hold their last value when the buffer drains without a refill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_flag  <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_id    <= ID_W'(sel);
      rsp_flag  <= flag_c;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  assign rsp_result = {XLEN{rsp_flag}};

endmodule

// File: tb/tb_cmp_arbiter.sv
// Self-checking bench for cmp_arbiter against a transaction-level reference model.
module tb_cmp_arbiter;
  import cmp_pkg::*;

  localparam int unsigned XLEN = 64;
  localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};

  logic            clk = 1'b0;
  logic            rst;
  logic            req0_valid, req0_ready, req1_valid, req1_ready;
  logic [XLEN-1:0] req0_src1, req0_src2, req1_src1, req1_src2;
  logic [OP_W-1:0] req0_op, req1_op;
  logic            rsp_valid, rsp_ready, rsp_flag;
  logic [ID_W-1:0] rsp_id;
  logic [XLEN-1:0] rsp_result;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: priority pointer plus the buffered transaction.
  logic m_last, m_valid, m_id, m_flag;
  logic e_r0, e_r1;

  cmp_arbiter #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_src1(req0_src1),
    .req0_src2(req0_src2), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_src1(req1_src1),
    .req1_src2(req1_src2), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flag(rsp_flag)
  );

  always #5 clk = ~clk;

  function automatic logic ref_flag(input logic [3:0] op, input logic [XLEN-1:0] a,
                                    input logic [XLEN-1:0] b);
    longint sa = a;
    longint sb = b;
    case (op)
      4'd0:    return a != b;
      4'd1:    return a == b;
      4'd2:    return !(sa < sb);
      4'd3:    return sa < sb;
      4'd4:    return a < b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [XLEN+2:0] model_rsp();
    return {m_valid, m_id, m_flag, {XLEN{m_flag}}};
  endfunction

  task automatic model_reset();
    m_last = 1'b1; m_valid = 1'b0; m_id = 1'b0; m_flag = 1'b0;
  endtask

  // Expected readies for the inputs currently applied.
  task automatic settle();
    logic free, win;
    #1;
    free = !m_valid || rsp_ready;
`ifdef CMP_ARB_FIXED_PRIO_EN
    win = (req0_valid && req1_valid) ? 1'b0 : req1_valid;
`else
    win = (req0_valid && req1_valid) ? !m_last : req1_valid;
`endif
    e_r0 = !rst && free && req0_valid && !win;
    e_r1 = !rst && free && req1_valid && win;
  endtask

  // Advance one edge and update the model with the accepted transaction.
  task automatic tick();
    @(posedge clk);
    if (e_r0 || e_r1) begin
      m_valid = 1'b1;
      m_id    = e_r1;
      m_last  = e_r1;
      m_flag  = e_r1 ? ref_flag(req1_op, req1_src1, req1_src2)
                     : ref_flag(req0_op, req0_src1, req0_src2);
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_op = '0; req1_op = '0;
    req0_src1 = '0; req0_src2 = '0; req1_src1 = '0; req1_src2 = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    req0_valid = 1; req0_op = 4'd1; req0_src1 = 64'd5; req0_src2 = 64'd5; rsp_ready = 1;
    settle();
    n_cmp++;
    if ({req1_ready, req0_ready} !== 2'b00) begin
      n_err++; $display("FAIL ready_in_reset: got %b want 00", {req1_ready, req0_ready});
    end
    @(negedge clk);
    rst = 0; req0_valid = 0;
    settle();
    n_cmp++;
    if ({req1_ready, req0_ready, rsp_valid, rsp_id, rsp_flag, rsp_result} !== '0) begin
      n_err++; $display("FAIL reset_outputs: got r=%b%b v=%b id=%b f=%b res=%h want all 0",
                        req1_ready, req0_ready, rsp_valid, rsp_id, rsp_flag, rsp_result);
    end
    @(negedge clk);
    req0_valid = 1;
    settle();
    n_cmp++;
    if ({req1_ready, req0_ready} !== 2'b01 || req0_ready !== e_r0) begin
      n_err++; $display("FAIL first_ready: got %b want 01", {req1_ready, req0_ready});
    end
    tick();
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_flag, rsp_result} !== {3'b101, ONES}) begin
      n_err++; $display("FAIL first_rsp: got v=%b id=%b res=%h want v=1 id=0 res=%h",
                        rsp_valid, rsp_id, rsp_result, ONES);
    end
  endtask

  task automatic test_signed();
    logic [3:0] ops  [4] = '{4'd3, 4'd4, 4'd2, 4'd9};
    logic       want [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req0_valid = 0; req1_valid = 1; rsp_ready = 1;
      req1_src1 = ONES; req1_src2 = 64'd1; req1_op = ops[i];
      settle();
      tick();
      n_cmp++;
      if ({rsp_valid, rsp_id, rsp_flag, rsp_result} !== {2'b11, want[i], {XLEN{want[i]}}} ||
          {rsp_valid, rsp_id, rsp_flag, rsp_result} !== model_rsp()) begin
        n_err++; $display("FAIL signed_op%0d: got v=%b id=%b f=%b res=%h want flag %b",
                          ops[i], rsp_valid, rsp_id, rsp_flag, rsp_result, want[i]);
      end
    end
    req1_valid = 0;
  endtask

  task automatic test_contention();
    logic [3:0] want_id;
`ifdef CMP_ARB_FIXED_PRIO_EN
    want_id = 4'b0000;
`else
    want_id = 4'b1010;
`endif
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req0_valid = 1; req1_valid = 1; rsp_ready = 1;
      req0_op = 4'd0; req0_src1 = 64'(i); req0_src2 = 64'd1;
      req1_op = 4'd4; req1_src1 = 64'(i); req1_src2 = 64'd2;
      settle();
      tick();
      n_cmp++;
      if (rsp_id !== want_id[i] || {rsp_valid, rsp_id, rsp_flag, rsp_result} !== model_rsp()) begin
        n_err++; $display("FAIL contention_%0d: got id=%b f=%b want id=%b f=%b",
                          i, rsp_id, rsp_flag, want_id[i], m_flag);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [XLEN+2:0] snap;
    logic            want_id;
    @(negedge clk);
    req0_valid = 1; req1_valid = 1; rsp_ready = 1;
    settle();
    tick();
    snap = {rsp_valid, rsp_id, rsp_flag, rsp_result};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rsp_ready = 0;
      req0_src1 = 64'($urandom); req1_src1 = 64'($urandom);
      settle();
      n_cmp++;
      if ({req1_ready, req0_ready} !== 2'b00) begin
        n_err++; $display("FAIL bp_ready_%0d: got %b want 00", i, {req1_ready, req0_ready});
      end
      tick();
      n_cmp++;
      if ({rsp_valid, rsp_id, rsp_flag, rsp_result} !== snap) begin
        n_err++; $display("FAIL bp_hold_%0d: got %h want %h", i,
                          {rsp_valid, rsp_id, rsp_flag, rsp_result}, snap);
      end
    end
`ifdef CMP_ARB_FIXED_PRIO_EN
    want_id = 1'b0;
`else
    want_id = 1'b1;
`endif
    @(negedge clk);
    rsp_ready = 1;
    settle();
    tick();
    n_cmp++;
    if (rsp_id !== want_id || {rsp_valid, rsp_id, rsp_flag, rsp_result} !== model_rsp()) begin
      n_err++; $display("FAIL bp_resume: got id=%b v=%b want id=%b v=1", rsp_id, rsp_valid, want_id);
    end
    req1_valid = 0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req0_valid = 1; req1_valid = 0; rsp_ready = 1;
      req0_op = 4'(i % 5); req0_src1 = 64'($urandom_range(0, 3)); req0_src2 = 64'($urandom_range(0, 3));
      if (i % 2 == 1) req0_src1 = ONES;
      settle();
      n_cmp++;
      if (req0_ready !== 1'b1) begin
        n_err++; $display("FAIL b2b_ready_%0d: got %b want 1", i, req0_ready);
      end
      tick();
      n_cmp++;
      if (rsp_valid !== 1'b1 || {rsp_valid, rsp_id, rsp_flag, rsp_result} !== model_rsp()) begin
        n_err++; $display("FAIL b2b_rsp_%0d: got v=%b f=%b want v=1 f=%b", i, rsp_valid, rsp_flag, m_flag);
      end
    end
  endtask

  task automatic test_random();
    logic [XLEN-1:0] a0, a1;
    logic [3:0]      o0, o1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!req0_valid) begin
        a0 = {$urandom, $urandom};
        req0_valid = ($urandom_range(0, 2) != 0); req0_op = 4'($urandom_range(0, 15));
        req0_src1 = a0; req0_src2 = ($urandom_range(0, 3) == 0) ? a0 : {$urandom, $urandom};
      end
      if (!req1_valid) begin
        a1 = {$urandom, $urandom};
        req1_valid = ($urandom_range(0, 2) != 0); req1_op = 4'($urandom_range(0, 7));
        req1_src1 = a1; req1_src2 = ($urandom_range(0, 3) == 0) ? a1 : {$urandom, $urandom};
      end
      rsp_ready = ($urandom_range(0, 9) < 7);
      settle();
      n_cmp++;
      if ({req1_ready, req0_ready} !== {e_r1, e_r0}) begin
        n_err++; $display("FAIL rand_ready_%0d: got %b want %b", i, {req1_ready, req0_ready}, {e_r1, e_r0});
      end
      o0 = req0_op; o1 = req1_op;
      tick();
      n_cmp++;
      if ({rsp_valid, rsp_id, rsp_flag, rsp_result} !== model_rsp()) begin
        n_err++; $display("FAIL rand_rsp_%0d: got v=%b id=%b f=%b want v=%b id=%b f=%b (ops %0d/%0d)",
                          i, rsp_valid, rsp_id, rsp_flag, m_valid, m_id, m_flag, o0, o1);
      end
      if (e_r0) req0_valid = 0;
      if (e_r1) req1_valid = 0;
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    req0_valid = 1; req1_valid = 0; rsp_ready = 0; req0_op = 4'd1; req0_src1 = '0; req0_src2 = '0;
    settle();
    tick();
    @(negedge clk);
    req0_valid = 0;
    settle();
    n_cmp++;
    if (rsp_valid !== 1'b1) begin
      n_err++; $display("FAIL arst_pre: got v=%b want 1", rsp_valid);
    end
    #2;
    rst = 1;
    #1;
    model_reset();
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_flag, rsp_result, req1_ready, req0_ready} !== '0) begin
      n_err++; $display("FAIL arst_clear: got v=%b id=%b f=%b r=%b%b want all 0",
                        rsp_valid, rsp_id, rsp_flag, req1_ready, req0_ready);
    end
    @(negedge clk);
    rst = 0; req0_valid = 1; req1_valid = 1; rsp_ready = 1;
    settle();
    n_cmp++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      n_err++; $display("FAIL arst_grant: got %b want 01", {req1_ready, req0_ready});
    end
    tick();
    n_cmp++;
    if ({rsp_valid, rsp_id} !== 2'b10 || {rsp_valid, rsp_id, rsp_flag, rsp_result} !== model_rsp()) begin
      n_err++; $display("FAIL arst_rsp: got v=%b id=%b want v=1 id=0", rsp_valid, rsp_id);
    end
    req0_valid = 0; req1_valid = 0;
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    test_reset();
    test_signed();
    test_contention();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_async_reset();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule
